// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the synchronous instruction memory (instr_mem_sync):
//   NOP_WORD       - instruction emitted whenever there is no real fetch
//   fault_e        - fault codes produced by the fetch address decode
//   action_e       - what the fetch stage does on a given clock edge
//   word_index()   - converts a PC into a word index
//   decode_fault() - range / alignment check of a fetch PC
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [1:0] FAULT_CODE_NONE     = 2'd0;
  localparam logic [1:0] FAULT_CODE_RANGE    = 2'd1;
  localparam logic [1:0] FAULT_CODE_MISALIGN = 2'd2;

  typedef enum logic [1:0] {
    FAULT_NONE     = FAULT_CODE_NONE,
    FAULT_RANGE    = FAULT_CODE_RANGE,
    FAULT_MISALIGN = FAULT_CODE_MISALIGN
  } fault_e;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_FETCH,
    ACT_STALL,
    ACT_FLUSH
  } action_e;

  // The PC is handled zero-extended to 64 bits so one function serves any
  // PC_W up to 64.
  function automatic logic [63:0] word_index(input logic [63:0] pc,
                                             input bit          byte_addr);
    return byte_addr ? (pc >> 2) : pc;
  endfunction

  // Comparing the full-width word index against DEPTH covers both an index
  // past the end of the array and any nonzero PC bits above the index field,
  // because DEPTH never exceeds 2**AW.
  function automatic fault_e decode_fault(input logic [63:0] pc,
                                          input int unsigned depth,
                                          input bit          byte_addr);
    if (byte_addr && (pc[1:0] != 2'b00)) return FAULT_MISALIGN;
    if (word_index(pc, byte_addr) >= 64'(depth)) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

  function automatic bit index_in_range(input int unsigned idx,
                                        input int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
// DEPTH x DATA_W instruction storage with one synchronous read port and one
// synchronous write port. A read and a write to the same word on the same
// edge return the old contents (read-before-write).
// Ports:
//   clk      in   rising-edge clock
//   rd_en    in   capture mem[rd_addr] into rd_data on this edge
//   rd_addr  in   read word index (caller guarantees < DEPTH when rd_en)
//   rd_data  out  registered read data, holds when rd_en is low
//   wr_en    in   write strobe (caller guarantees wr_addr < DEPTH)
//   wr_addr  in   write word index
//   wr_data  in   write data
// ---------------------------------------------------------------------------
module imem_array
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 32,
  parameter int    AW        = 5,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Power-up image: an array of NOPs; programs arrive through the loader.
  // The contents are deliberately never touched by reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(NOP_WORD);
  end

  // Both ports sample the array before the write lands, which gives the
  // read-before-write behaviour the loader relies on.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// ---------------------------------------------------------------------------
// instr_mem_sync
// Registered instruction memory for the IF stage. A fetch accepted on one
// edge appears on the outputs after that edge (1-cycle latency). Supports
// stall/flush from the hazard unit, byte- or word-addressed PC, a fault flag
// for out-of-range or misaligned fetches, a run-time loader port and a
// count of accepted fetches.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   fetch_en_i   fetch at pc_i this cycle
//   stall_i      hold instr_o/pc_o/valid_o/fault_o
//   flush_i      kill the next output (highest priority)
//   pc_i         fetch address
//   instr_o      fetched instruction, NOP_WORD when not a good fetch
//   pc_o         PC that produced instr_o
//   valid_o      instr_o belongs to an accepted fetch (faulted ones included)
//   fault_o      accepted fetch was out of range or misaligned
//   ld_we_i      loader write strobe
//   ld_addr_i    loader word index
//   ld_data_i    loader write data
//   ld_err_o     one-cycle pulse after a loader write to a missing word
//   fetch_cnt_o  accepted fetches since reset (wraps)
// ---------------------------------------------------------------------------
module instr_mem_sync
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 32,
  parameter int    PC_W      = 32,
  parameter int    BYTE_ADDR = 1,
  parameter string INIT_FILE = "",
  parameter int    CNT_W     = 16,
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_o,
  output logic              fault_o,
  input  logic              ld_we_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_err_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  action_e           action;
  fault_e            fault_code;
  logic [AW-1:0]     rd_addr;
  logic              rd_en;
  logic              ld_in_range;
  logic [DATA_W-1:0] rd_data;

  logic [PC_W-1:0]   pc_q;
  logic              valid_q;
  logic              fault_q;
  logic              use_mem_q;
  logic              ld_err_q;
  logic [CNT_W-1:0]  cnt_q;

  // Pick this edge's action (flush > stall > fetch > idle) and decode the
  // fetch address. The array is only read for a good fetch so that an
  // out-of-range index never reaches it.
  always_comb begin
    action      = ACT_IDLE;
    fault_code  = decode_fault(64'(pc_i), DEPTH, BYTE_ADDR != 0);
    rd_addr     = AW'(word_index(64'(pc_i), BYTE_ADDR != 0));
    ld_in_range = index_in_range(32'(ld_addr_i), DEPTH);
    if (flush_i)         action = ACT_FLUSH;
    else if (stall_i)    action = ACT_STALL;
    else if (fetch_en_i) action = ACT_FETCH;
    rd_en = (action == ACT_FETCH) && (fault_code == FAULT_NONE);
  end

  imem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (ld_we_i && ld_in_range),
    .wr_addr (ld_addr_i),
    .wr_data (ld_data_i)
  );

  // Output/control registers. use_mem_q selects the array read data onto
  // instr_o; clearing it is how flush, idle, faults and reset force a NOP
  // without having to reset the array's read register. A stall leaves both
  // use_mem_q and the (un-enabled) read register alone, so everything holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      use_mem_q <= 1'b0;
      ld_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ld_err_q <= ld_we_i && !ld_in_range;
      case (action)
        ACT_FETCH: begin
          pc_q      <= pc_i;
          valid_q   <= 1'b1;
          fault_q   <= (fault_code != FAULT_NONE);
          use_mem_q <= (fault_code == FAULT_NONE);
          cnt_q     <= cnt_q + CNT_W'(1);
        end
        ACT_STALL: begin
        end
        default: begin
          valid_q   <= 1'b0;
          fault_q   <= 1'b0;
          use_mem_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_o     = use_mem_q ? rd_data : DATA_W'(NOP_WORD);
  assign pc_o        = pc_q;
  assign valid_o     = valid_q;
  assign fault_o     = fault_q;
  assign ld_err_o    = ld_err_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_sync
// Self-checking bench for instr_mem_sync. DEPTH is 24 so that loader indices
// 24..31 fit the 5-bit loader port but name words that do not exist.
// ---------------------------------------------------------------------------
module tb_instr_mem_sync;

  localparam int DEPTH  = 24;
  localparam int AW     = 5;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_en_i = 1'b0;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [PC_W-1:0]   pc_i = '0;
  logic [DATA_W-1:0] instr_o;
  logic [PC_W-1:0]   pc_o;
  logic              valid_o;
  logic              fault_o;
  logic              ld_we_i = 1'b0;
  logic [AW-1:0]     ld_addr_i = '0;
  logic [DATA_W-1:0] ld_data_i = '0;
  logic              ld_err_o;
  logic [CNT_W-1:0]  fetch_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain array of words plus the expected output values.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic        exp_fault;
  logic        exp_lderr;
  logic [15:0] exp_cnt;

  instr_mem_sync #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PC_W      (PC_W),
    .BYTE_ADDR (1),
    .INIT_FILE (""),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en_i  (fetch_en_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o),
    .fault_o     (fault_o),
    .ld_we_i     (ld_we_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i),
    .ld_err_o    (ld_err_o),
    .fetch_cnt_o (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_instr = 32'h0;
    exp_pc    = 32'h0;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    exp_lderr = 1'b0;
    exp_cnt   = 16'h0;
  endtask

  // Drives one cycle of inputs (called just after a falling edge), lets the
  // rising edge happen, updates the model and returns on the next falling
  // edge where outputs are sampled.
  task automatic cycle(input bit fl, input bit st, input bit fe,
                       input logic [31:0] pc, input bit we,
                       input logic [4:0] la, input logic [31:0] ld);
    flush_i    = fl;
    stall_i    = st;
    fetch_en_i = fe;
    pc_i       = pc;
    ld_we_i    = we;
    ld_addr_i  = la;
    ld_data_i  = ld;
    @(posedge clk);
    if (fl) begin
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_instr = 32'h0;
    end else if (st) begin
      // outputs hold
    end else if (fe) begin
      exp_pc    = pc;
      exp_valid = 1'b1;
      exp_cnt   = exp_cnt + 16'd1;
      if ((pc % 4) != 0 || (pc / 4) >= DEPTH) begin
        exp_fault = 1'b1;
        exp_instr = 32'h0;
      end else begin
        exp_fault = 1'b0;
        exp_instr = model_mem[pc / 4];
      end
    end else begin
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_instr = 32'h0;
    end
    exp_lderr = we && (int'(la) >= DEPTH);
    if (we && int'(la) < DEPTH) model_mem[la] = ld;
    @(negedge clk);
    flush_i = 0; stall_i = 0; fetch_en_i = 0; ld_we_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({instr_o, pc_o, valid_o, fault_o, ld_err_o, fetch_cnt_o} !== '0)
      $display("[TB] FAIL reset_state: got instr=%h pc=%h v=%b f=%b err=%b cnt=%0d, expected all zero",
               instr_o, pc_o, valid_o, fault_o, ld_err_o, fetch_cnt_o);
    else n_pass++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_load_fetch();
    cycle(0, 0, 0, 32'h0, 1, 5'd0, 32'h8C01_0001);
    cycle(0, 0, 0, 32'h0, 1, 5'd1, 32'h1111_2222);
    cycle(0, 0, 0, 32'h0, 1, 5'd2, 32'h3333_4444);
    cycle(0, 0, 1, 32'h0, 0, 5'd0, 32'h0);
    n_checks++;
    if ({instr_o, valid_o, fetch_cnt_o} !== {32'h8C01_0001, 1'b1, 16'd1})
      $display("[TB] FAIL load_fetch: got instr=%h v=%b cnt=%0d, expected instr=8c010001 v=1 cnt=1",
               instr_o, valid_o, fetch_cnt_o);
    else n_pass++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 32'h4, 0, 5'd0, 32'h0);
      n_checks++;
      if ({instr_o, pc_o, valid_o, fault_o, fetch_cnt_o} !== {32'h8C01_0001, 32'h0, 1'b1, 1'b0, 16'd1})
        $display("[TB] FAIL stall_hold[%0d]: got instr=%h pc=%h v=%b f=%b cnt=%0d, expected 8c010001/0/1/0/1",
                 i, instr_o, pc_o, valid_o, fault_o, fetch_cnt_o);
      else n_pass++;
    end
    cycle(0, 0, 1, 32'h4, 0, 5'd0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, fetch_cnt_o} !== {32'h1111_2222, 32'h4, 16'd2})
      $display("[TB] FAIL stall_release: got instr=%h pc=%h cnt=%0d, expected 11112222/4/2",
               instr_o, pc_o, fetch_cnt_o);
    else n_pass++;
  endtask

  task automatic test_fault();
    logic [31:0] pcs [4];
    pcs[0] = 32'h80; pcs[1] = 32'h6; pcs[2] = 32'h60; pcs[3] = 32'h1_0000_000;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, pcs[i], 0, 5'd0, 32'h0);
      n_checks++;
      if ({instr_o, fault_o, valid_o, pc_o} !== {32'h0, 1'b1, 1'b1, pcs[i]})
        $display("[TB] FAIL fault_pc_%h: got instr=%h f=%b v=%b pc=%h, expected 0/1/1/%h",
                 pcs[i], instr_o, fault_o, valid_o, pc_o, pcs[i]);
      else n_pass++;
    end
    cycle(0, 0, 1, 32'h4, 0, 5'd0, 32'h0);
    n_checks++;
    if ({instr_o, fault_o} !== {32'h1111_2222, 1'b0})
      $display("[TB] FAIL fault_clears: got instr=%h f=%b, expected 11112222/0", instr_o, fault_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    cnt_before = exp_cnt;
    cycle(1, 1, 1, 32'h8, 0, 5'd0, 32'h0);
    n_checks++;
    if ({instr_o, valid_o, fault_o, pc_o, fetch_cnt_o} !== {32'h0, 1'b0, 1'b0, 32'h4, cnt_before})
      $display("[TB] FAIL flush_priority: got instr=%h v=%b f=%b pc=%h cnt=%0d, expected 0/0/0/4/%0d",
               instr_o, valid_o, fault_o, pc_o, fetch_cnt_o, cnt_before);
    else n_pass++;
    cycle(0, 0, 1, 32'h0, 0, 5'd0, 32'h0);
    cycle(0, 0, 0, 32'h8, 0, 5'd0, 32'h0);
    n_checks++;
    if ({instr_o, valid_o, pc_o} !== {32'h0, 1'b0, 32'h0})
      $display("[TB] FAIL idle: got instr=%h v=%b pc=%h, expected 0/0/0", instr_o, valid_o, pc_o);
    else n_pass++;
  endtask

  task automatic test_loader();
    cycle(0, 0, 1, 32'h8, 1, 5'd2, 32'hDEAD_BEEF);
    n_checks++;
    if (instr_o !== 32'h3333_4444)
      $display("[TB] FAIL read_before_write: got %h, expected 33334444", instr_o);
    else n_pass++;
    cycle(0, 0, 1, 32'h8, 0, 5'd0, 32'h0);
    n_checks++;
    if (instr_o !== 32'hDEAD_BEEF)
      $display("[TB] FAIL write_visible: got %h, expected deadbeef", instr_o);
    else n_pass++;
    cycle(0, 0, 0, 32'h0, 1, 5'd28, 32'hBAD0_BAD0);
    n_checks++;
    if (ld_err_o !== 1'b1)
      $display("[TB] FAIL ld_err_pulse: got %b, expected 1", ld_err_o);
    else n_pass++;
    cycle(0, 0, 1, 32'h10, 0, 5'd0, 32'h0);
    n_checks++;
    if ({ld_err_o, instr_o} !== {1'b0, model_mem[4]})
      $display("[TB] FAIL ld_err_clear: got err=%b instr=%h, expected 0/%h", ld_err_o, instr_o, model_mem[4]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1, 32'h8, 0, 5'd0, 32'h0);
    fetch_en_i = 1'b1;
    pc_i       = 32'hC;
    #2 reset   = 1'b1;
    #1;
    n_checks++;
    if ({instr_o, pc_o, valid_o, fault_o, ld_err_o, fetch_cnt_o} !== '0)
      $display("[TB] FAIL async_reset: got instr=%h pc=%h v=%b f=%b cnt=%0d, expected all zero",
               instr_o, pc_o, valid_o, fault_o, fetch_cnt_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({valid_o, fetch_cnt_o} !== '0)
      $display("[TB] FAIL reset_discard: got v=%b cnt=%0d, expected 0/0", valid_o, fetch_cnt_o);
    else n_pass++;
    fetch_en_i = 1'b0;
    reset = 1'b0;
    model_reset();
    cycle(0, 0, 1, 32'h8, 0, 5'd0, 32'h0);
    n_checks++;
    if ({instr_o, fetch_cnt_o} !== {32'hDEAD_BEEF, 16'd1})
      $display("[TB] FAIL mem_retained: got instr=%h cnt=%0d, expected deadbeef/1", instr_o, fetch_cnt_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 127))
                                       : 32'($urandom_range(0, DEPTH - 1) * 4);
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) == 0,
            5'($urandom_range(0, 31)), $urandom);
      n_checks++;
      if ({instr_o, pc_o, valid_o, fault_o, ld_err_o, fetch_cnt_o} !==
          {exp_instr, exp_pc, exp_valid, exp_fault, exp_lderr, exp_cnt}) begin
        if (errs < 10)
          $display("[TB] FAIL random[%0d]: got instr=%h pc=%h v=%b f=%b err=%b cnt=%0d, expected %h/%h/%b/%b/%b/%0d",
                   i, instr_o, pc_o, valid_o, fault_o, ld_err_o, fetch_cnt_o,
                   exp_instr, exp_pc, exp_valid, exp_fault, exp_lderr, exp_cnt);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_reset();
    test_reset();
    test_load_fetch();
    test_stall();
    test_fault();
    test_flush();
    test_loader();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
